// File: rtl/quick_spi_peripheral.sv
// SPI peripheral endpoint for the quick_spi protocol: SCLK idles high, sample on rise, shift on fall, MSB first.
// Optional MISO output-enable port and gating under QUICK_SPI_PERIPHERAL_MISO_TRISTATE_EN.
module quick_spi_peripheral #(
  parameter int unsigned MAX_DATA_LENGTH = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        IDLE_FILL       = 1'b0,
  localparam int unsigned CW             = $clog2(MAX_DATA_LENGTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sclk_i,
  input  logic                       cs_n_i,
  input  logic                       sdata_i,
  output logic                       sdata_o,
`ifdef QUICK_SPI_PERIPHERAL_MISO_TRISTATE_EN
  output logic                       sdata_oe_o,
`endif
  input  logic [MAX_DATA_LENGTH-1:0] tx_data_i,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  output logic [MAX_DATA_LENGTH-1:0] rx_data_o,
  output logic [CW-1:0]              rx_count_o,
  output logic                       rx_valid_o,
  output logic                       busy_o,
  output logic                       tx_underrun_o
);

  localparam int unsigned N  = MAX_DATA_LENGTH;
  localparam int unsigned SW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdata_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, sdata_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SW-1:0]          settle_cnt;
  logic                   settle_done;

  logic [N-1:0]  hold_data;
  logic [N-1:0]  tx_shift, tx_shift_next;
  logic [N-1:0]  rx_shift;
  logic [CW-1:0] bit_cnt;
  logic          first_fall;

  logic frame_start, frame_end, rx_shift_en, tx_shift_en, first_fall_clr;
  logic sdata_next;

  // Input synchronizers plus one extra copy for edge detection; idle level is 1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync  <= '1;
      cs_sync    <= '1;
      sdata_sync <= '1;
      sclk_q     <= 1'b1;
      cs_q       <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_i};
      sclk_q     <= sclk_sync[SYNC_STAGES-1];
      cs_q       <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  // The synchronizers reset to idle, so wait for them to flush real pin levels before trusting cs_n
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_cnt <= '0;
    end else if (!settle_done) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  assign settle_done = (settle_cnt == SW'(SYNC_STAGES + 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RESYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle datapath controls; a cs edge masks any coincident sclk edge
  always_comb begin
    state_next     = state;
    frame_start    = 1'b0;
    frame_end      = 1'b0;
    rx_shift_en    = 1'b0;
    tx_shift_en    = 1'b0;
    first_fall_clr = 1'b0;
    unique case (state)
      RESYNC: begin
        if (settle_done && cs_s) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end else begin
          rx_shift_en = sclk_rise;
          if (sclk_fall) begin
            first_fall_clr = first_fall;
            tx_shift_en    = ~first_fall;
          end
        end
      end
      default: state_next = RESYNC;
    endcase

    tx_shift_next = tx_shift;
    if (frame_start) begin
      tx_shift_next = tx_ready_o ? {N{IDLE_FILL}} : hold_data;
    end else if (tx_shift_en) begin
      tx_shift_next = {tx_shift[N-2:0], IDLE_FILL};
    end

`ifdef QUICK_SPI_PERIPHERAL_MISO_TRISTATE_EN
    sdata_next = (state_next == ACTIVE) ? tx_shift_next[N-1] : 1'b0;
`else
    sdata_next = tx_shift_next[N-1];
`endif
  end

  // TX holding register: a full word is consumed at frame start, an empty one may refill that same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_ready_o <= 1'b1;
      hold_data  <= '0;
    end else if (frame_start && !tx_ready_o) begin
      tx_ready_o <= 1'b1;
    end else if (tx_valid_i && tx_ready_o) begin
      tx_ready_o <= 1'b0;
      hold_data  <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_shift      <= {N{IDLE_FILL}};
`ifdef QUICK_SPI_PERIPHERAL_MISO_TRISTATE_EN
      sdata_o       <= 1'b0;
      sdata_oe_o    <= 1'b0;
`else
      sdata_o       <= IDLE_FILL;
`endif
      rx_shift      <= '0;
      bit_cnt       <= '0;
      first_fall    <= 1'b0;
      rx_data_o     <= '0;
      rx_count_o    <= '0;
      rx_valid_o    <= 1'b0;
      busy_o        <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      tx_shift      <= tx_shift_next;
      sdata_o       <= sdata_next;
`ifdef QUICK_SPI_PERIPHERAL_MISO_TRISTATE_EN
      sdata_oe_o    <= (state_next == ACTIVE);
`endif
      busy_o        <= (state_next == ACTIVE);
      tx_underrun_o <= frame_start & tx_ready_o;
      rx_valid_o    <= frame_end & (bit_cnt != '0);

      if (frame_start) begin
        rx_shift   <= '0;
        bit_cnt    <= '0;
        first_fall <= 1'b1;
      end else begin
        if (rx_shift_en) begin
          rx_shift <= {rx_shift[N-2:0], sdata_s};
          if (bit_cnt != CW'(N)) begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        if (first_fall_clr) begin
          first_fall <= 1'b0;
        end
      end

      if (frame_end && (bit_cnt != '0)) begin
        rx_data_o  <= rx_shift;
        rx_count_o <= bit_cnt;
      end
    end
  end

endmodule

// File: tb/tb_quick_spi_peripheral.sv
// Directed bench for quick_spi_peripheral acting as the SPI master, IDLE_FILL = 1.
module tb_quick_spi_peripheral;

  localparam int unsigned N  = 16;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int H = 5;  // SCLK half period in clk cycles

  logic          clk, rst_n;
  logic          sclk, cs_n, mosi, miso;
  logic [N-1:0]  tx_data;
  logic          tx_valid, tx_ready;
  logic [N-1:0]  rx_data;
  logic [CW-1:0] rx_count;
  logic          rx_valid, busy, tx_underrun;

  int checks = 0;
  int failures = 0;
  int rx_pulses = 0;
  int ur_pulses = 0;

  quick_spi_peripheral #(
    .MAX_DATA_LENGTH(N),
    .SYNC_STAGES(2),
    .IDLE_FILL(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .sclk_i(sclk),
    .cs_n_i(cs_n),
    .sdata_i(mosi),
    .sdata_o(miso),
    .tx_data_i(tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .rx_data_o(rx_data),
    .rx_count_o(rx_count),
    .rx_valid_o(rx_valid),
    .busy_o(busy),
    .tx_underrun_o(tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (tx_underrun) ur_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One SCLK period: fall (drive MOSI), then rise (sample MISO)
  task automatic sclk_bit(input logic b, output logic s);
    sclk = 1'b0;
    mosi = b;
    repeat (H) @(negedge clk);
    sclk = 1'b1;
    s = miso;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [31:0] d, input int nbits, output logic [31:0] r);
    logic s;
    r = '0;
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk_bit(d[i], s);
      r = {r[30:0], s};
    end
    cs_n = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic        s;
    int          rx0, ur0;

    rst_n = 1'b0; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sdata", 32'(miso), 32'h1);
    check("rst_ready", 32'(tx_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_count", 32'(rx_count), 32'h0);
    check("rst_underrun", 32'(tx_underrun), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Queued word, full 16-bit frame
    push(16'hA5C3);
    check("push_ready_low", 32'(tx_ready), 32'h0);
    rx0 = rx_pulses; ur0 = ur_pulses;
    spi_frame(32'h1234, 16, r);
    check("f1_miso", r, 32'hA5C3);
    check("f1_rx_pulses", 32'(rx_pulses - rx0), 32'h1);
    check("f1_rx_data", 32'(rx_data), 32'h1234);
    check("f1_rx_count", 32'(rx_count), 32'd16);
    check("f1_no_underrun", 32'(ur_pulses - ur0), 32'h0);
    check("f1_ready", 32'(tx_ready), 32'h1);

    // Underrun frame
    rx0 = rx_pulses; ur0 = ur_pulses;
    spi_frame(32'h0F0F, 16, r);
    check("f2_miso", r, 32'hFFFF);
    check("f2_underrun", 32'(ur_pulses - ur0), 32'h1);
    check("f2_ready", 32'(tx_ready), 32'h1);
    check("f2_rx_data", 32'(rx_data), 32'h0F0F);

    // Short 8-bit frame
    rx0 = rx_pulses;
    spi_frame(32'h5A, 8, r);
    check("f3_rx_pulses", 32'(rx_pulses - rx0), 32'h1);
    check("f3_rx_data", 32'(rx_data), 32'h005A);
    check("f3_rx_count", 32'(rx_count), 32'd8);
    check("f3_miso", r, 32'hFF);

    // 17 rising edges: count saturates, last 16 bits kept, TX shifts IDLE_FILL in
    push(16'h8001);
    spi_frame(32'h17DDF, 17, r);
    check("f4_rx_count", 32'(rx_count), 32'd16);
    check("f4_rx_data", 32'(rx_data), 32'h7DDF);
    check("f4_miso", r, 32'h10003);

    // Async reset mid-frame, released with cs_n still low
    push(16'h1111);
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 4; i++) sclk_bit(1'b1, s);
    check("f5_busy_mid", 32'(busy), 32'h1);
    push(16'h2222);
    check("f5_held", 32'(tx_ready), 32'h0);
    rx0 = rx_pulses;
    rst_n = 1'b0;
    #2;
    check("f5_busy_rst", 32'(busy), 32'h0);
    check("f5_ready_rst", 32'(tx_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sclk_bit(1'b0, s);
    check("f5_busy_after", 32'(busy), 32'h0);
    cs_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    check("f5_no_rx", 32'(rx_pulses - rx0), 32'h0);
    check("f5_busy_idle", 32'(busy), 32'h0);
    push(16'h3C3C);
    rx0 = rx_pulses;
    spi_frame(32'hCAFE, 16, r);
    check("f5_miso", r, 32'h3C3C);
    check("f5_rx_pulses", 32'(rx_pulses - rx0), 32'h1);
    check("f5_rx_data", 32'(rx_data), 32'hCAFE);
    check("f5_rx_count", 32'(rx_count), 32'd16);

    // CS pulse without SCLK edges consumes the held word, no RX strobe
    push(16'h7777);
    check("f6_ready_low", 32'(tx_ready), 32'h0);
    rx0 = rx_pulses; ur0 = ur_pulses;
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    check("f6_busy", 32'(busy), 32'h1);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("f6_ready", 32'(tx_ready), 32'h1);
    check("f6_no_rx", 32'(rx_pulses - rx0), 32'h0);
    check("f6_no_underrun", 32'(ur_pulses - ur0), 32'h0);
    check("f6_rx_data_kept", 32'(rx_data), 32'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
